// File: rtl/knn_mem_pkg.sv
// Shared types and address helpers for the multi-channel KNN memory controller.
package knn_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_IN,
        ST_FETCH_TR,
        ST_SEND,
        ST_WAIT_DONE,
        ST_WAIT_INF,
        ST_WRITE,
        ST_NEXT
    } state_t;

    typedef logic [63:0] addr_t;

    // Record layout: word 0 is the type, words 1..f are features.
    function automatic int unsigned rec_stride(input int unsigned w, input int unsigned f);
        return (f + 1) * (w / 8);
    endfunction

    function automatic addr_t rec_addr(input addr_t base, input int unsigned idx,
                                       input int unsigned stride);
        return base + addr_t'(idx) * addr_t'(stride);
    endfunction

    function automatic addr_t word_addr(input addr_t rec, input int unsigned k,
                                        input int unsigned step);
        return rec + addr_t'(k) * addr_t'(step);
    endfunction

endpackage

// File: rtl/knn_mm_reader.sv
// Single-outstanding read engine: read/addr held while waitrequest, data_valid pulses the cycle
// after readdatavalid. Requests while busy and readdatavalid with nothing outstanding are dropped.
module knn_mm_reader #(
    parameter int                W        = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              waitrequest,
    input  logic              readdatavalid,
    input  logic [W-1:0]      readdata,
    output logic              read,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              data_valid,
    output logic [W-1:0]      data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read       <= 1'b0;
            addr       <= RST_ADDR;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            data       <= '0;
        end else begin
            data_valid <= 1'b0;
            if (!busy) begin
                if (req) begin
                    read <= 1'b1;
                    addr <= req_addr;
                    busy <= 1'b1;
                end
            end else if (read) begin
                if (!waitrequest)
                    read <= 1'b0;
            end else if (readdatavalid) begin
                // Accepted earlier, so this beat belongs to our request.
                data       <= readdata;
                data_valid <= 1'b1;
                busy       <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/knn_memory_control_mc.sv
// Memory master for the KNN datapath: fetches an input vector, streams training records in batches
// of P, writes back the inferred type. Every memory access waits on waitrequest/readdatavalid.
module knn_memory_control_mc
    import knn_mem_pkg::*;
#(
    parameter int                W           = 32,
    parameter int                M           = 4,
    parameter int                N           = 4,
    parameter int                TYPE_W      = 4,
    parameter int                L           = 16,
    parameter int                P           = 2,
    parameter int                NUM_INPUTS  = 4,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_T_ADDR = '0,
    parameter logic [ADDR_W-1:0] BASE_I_ADDR = 'h1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  waitrequest,
    input  logic                  readdatavalid,
    input  logic [W-1:0]          readdata,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_W-1:0]     address,
    output logic [W-1:0]          writedata,
    output logic [W*M*N-1:0]      input_data,
    output logic [P*W*M*N-1:0]    training_data,
    output logic [P*TYPE_W-1:0]   training_data_type,
    output logic [P-1:0]          channel_valid,
    output logic                  read_done,
    input  logic                  done,
    input  logic                  inference_done,
    input  logic [TYPE_W-1:0]     inferred_type,
    output logic                  run_done,
    output logic                  idle
);

    localparam int F    = M * N;
    localparam int S    = W / 8;
    localparam int R    = int'(rec_stride(W, F));
    localparam int T_W  = $clog2(L + 1);
    localparam int I_W  = $clog2(NUM_INPUTS + 1);
    localparam int WC_W = $clog2(F + 1);
    localparam int CH_W = $clog2(P + 1);
    localparam addr_t T_BASE = addr_t'(BASE_T_ADDR);
    localparam addr_t I_BASE = addr_t'(BASE_I_ADDR);

    state_t             state;
    logic [T_W-1:0]     t_cnt;
    logic [I_W-1:0]     i_cnt;
    logic [WC_W-1:0]    w_cnt;
    logic [CH_W-1:0]    ch;
    logic               rd_req;
    logic               rd_wait;
    logic [ADDR_W-1:0]  rd_req_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  wr_addr;
    logic               rd_busy;
    logic               rd_dvld;
    logic [W-1:0]       rd_data;
    logic               inf_flag;
    logic [TYPE_W-1:0]  inf_type;

    logic [W-1:0]       in_words [F];
    logic [W-1:0]       stg_tr   [P][F];
    logic [W-1:0]       out_tr   [P][F];
    logic [TYPE_W-1:0]  stg_type [P];
    logic [TYPE_W-1:0]  out_type [P];
    logic [P-1:0]       stg_vld;

    knn_mm_reader #(
        .W        (W),
        .ADDR_W   (ADDR_W),
        .RST_ADDR (BASE_T_ADDR)
    ) u_reader (
        .clk           (clk),
        .rst           (rst),
        .req           (rd_req),
        .req_addr      (rd_req_addr),
        .waitrequest   (waitrequest),
        .readdatavalid (readdatavalid),
        .readdata      (readdata),
        .read          (read),
        .addr          (rd_addr),
        .busy          (rd_busy),
        .data_valid    (rd_dvld),
        .data          (rd_data)
    );

    assign address = write ? wr_addr : rd_addr;
    assign idle    = (state == ST_IDLE);

    for (genvar k = 0; k < F; k++) begin : g_in
        assign input_data[k*W +: W] = in_words[k];
    end

    for (genvar c = 0; c < P; c++) begin : g_ch
        assign training_data_type[c*TYPE_W +: TYPE_W] = out_type[c];
        for (genvar k = 0; k < F; k++) begin : g_w
            assign training_data[(c*F + k)*W +: W] = out_tr[c][k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            t_cnt         <= '0;
            i_cnt         <= '0;
            w_cnt         <= '0;
            ch            <= '0;
            rd_req        <= 1'b0;
            rd_wait       <= 1'b0;
            rd_req_addr   <= BASE_T_ADDR;
            write         <= 1'b0;
            wr_addr       <= BASE_T_ADDR;
            writedata     <= '0;
            read_done     <= 1'b0;
            run_done      <= 1'b0;
            inf_flag      <= 1'b0;
            inf_type      <= '0;
            stg_vld       <= '0;
            channel_valid <= '0;
            for (int k = 0; k < F; k++)
                in_words[k] <= '0;
            for (int c = 0; c < P; c++) begin
                stg_type[c] <= '0;
                out_type[c] <= '0;
                for (int k = 0; k < F; k++) begin
                    stg_tr[c][k] <= '0;
                    out_tr[c][k] <= '0;
                end
            end
        end else begin
            rd_req    <= 1'b0;
            read_done <= 1'b0;
            run_done  <= 1'b0;

            // The classifier may finish while batches are still streaming; remember the latest result.
            if (state != ST_IDLE && inference_done) begin
                inf_flag <= 1'b1;
                inf_type <= inferred_type;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        w_cnt <= '0;
                        state <= ST_FETCH_IN;
                    end
                end

                ST_FETCH_IN: begin
                    if (!rd_wait && !rd_busy) begin
                        rd_req      <= 1'b1;
                        rd_wait     <= 1'b1;
                        rd_req_addr <= ADDR_W'(word_addr(rec_addr(I_BASE, 32'(i_cnt), R),
                                                         32'(w_cnt) + 32'd1, S));
                    end else if (rd_dvld) begin
                        rd_wait <= 1'b0;
                        for (int k = 0; k < F; k++)
                            if (w_cnt == WC_W'(k)) in_words[k] <= rd_data;
                        if (w_cnt == WC_W'(F - 1)) begin
                            w_cnt <= '0;
                            ch    <= '0;
                            state <= ST_FETCH_TR;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end

                ST_FETCH_TR: begin
                    if (t_cnt >= T_W'(L)) begin
                        // Out of records: this slot carries nothing for the tail batch.
                        for (int c = 0; c < P; c++) begin
                            if (ch == CH_W'(c)) begin
                                stg_vld[c]  <= 1'b0;
                                stg_type[c] <= '0;
                                for (int k = 0; k < F; k++)
                                    stg_tr[c][k] <= '0;
                            end
                        end
                        if (ch == CH_W'(P - 1)) state <= ST_SEND;
                        else                    ch    <= ch + 1'b1;
                    end else if (!rd_wait && !rd_busy) begin
                        rd_req      <= 1'b1;
                        rd_wait     <= 1'b1;
                        rd_req_addr <= ADDR_W'(word_addr(rec_addr(T_BASE, 32'(t_cnt), R),
                                                         32'(w_cnt), S));
                    end else if (rd_dvld) begin
                        rd_wait <= 1'b0;
                        for (int c = 0; c < P; c++) begin
                            if (ch == CH_W'(c)) begin
                                if (w_cnt == '0) stg_type[c] <= rd_data[TYPE_W-1:0];
                                for (int k = 0; k < F; k++)
                                    if (w_cnt == WC_W'(k + 1)) stg_tr[c][k] <= rd_data;
                                if (w_cnt == WC_W'(F)) stg_vld[c] <= 1'b1;
                            end
                        end
                        if (w_cnt == WC_W'(F)) begin
                            w_cnt <= '0;
                            t_cnt <= t_cnt + 1'b1;
                            if (ch == CH_W'(P - 1)) state <= ST_SEND;
                            else                    ch    <= ch + 1'b1;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end

                ST_SEND: begin
                    // Staging keeps the published batch stable while the next one is fetched.
                    out_tr        <= stg_tr;
                    out_type      <= stg_type;
                    channel_valid <= stg_vld;
                    read_done     <= 1'b1;
                    state         <= ST_WAIT_DONE;
                end

                ST_WAIT_DONE: begin
                    if (done) begin
                        if (t_cnt < T_W'(L)) begin
                            ch    <= '0;
                            w_cnt <= '0;
                            state <= ST_FETCH_TR;
                        end else begin
                            state <= ST_WAIT_INF;
                        end
                    end
                end

                ST_WAIT_INF: begin
                    if (inf_flag || inference_done) begin
                        write     <= 1'b1;
                        wr_addr   <= ADDR_W'(rec_addr(I_BASE, 32'(i_cnt), R));
                        writedata <= W'(inference_done ? inferred_type : inf_type);
                        state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (!waitrequest) begin
                        write <= 1'b0;
                        state <= ST_NEXT;
                    end
                end

                ST_NEXT: begin
                    inf_flag <= 1'b0;
                    t_cnt    <= '0;
                    w_cnt    <= '0;
                    if (i_cnt == I_W'(NUM_INPUTS - 1)) begin
                        i_cnt    <= '0;
                        run_done <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        i_cnt <= i_cnt + 1'b1;
                        state <= ST_FETCH_IN;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_memory_control_mc.sv
// Randomized bench: behavioural memory with stalls/latency and a reference model of the read/write traffic.
module tb_knn_memory_control_mc;

    localparam int W = 16, M = 2, N = 2, F = M * N, TYPE_W = 4, L = 3, P = 2, NI = 2, ADDR_W = 32;
    localparam logic [31:0] BT = 32'h0;
    localparam logic [31:0] BI = 32'h100;
    localparam int S = W / 8, R = (F + 1) * S, NB = (L + P - 1) / P;

    typedef struct {
        logic [F*W-1:0]     in_v;
        logic [P*F*W-1:0]   tr;
        logic [P*TYPE_W-1:0] ty;
        logic [P-1:0]       v;
    } batch_t;

    typedef struct {
        logic [31:0]  a;
        logic [W-1:0] d;
    } wr_t;

    logic                 clk, rst;
    logic                 start, done, inference_done;
    logic [TYPE_W-1:0]    inferred_type;
    logic                 waitrequest = 1'b0;
    logic                 readdatavalid = 1'b0;
    logic [W-1:0]         readdata = '0;
    logic                 read, write, read_done, run_done, idle;
    logic [ADDR_W-1:0]    address;
    logic [W-1:0]         writedata;
    logic [F*W-1:0]       input_data;
    logic [P*F*W-1:0]     training_data;
    logic [P*TYPE_W-1:0]  training_data_type;
    logic [P-1:0]         channel_valid;

    logic [W-1:0]         mem [256];
    logic [TYPE_W-1:0]    inf_t [NI];
    logic [31:0]          exp_rd [$];
    batch_t               exp_b [$];
    wr_t                  exp_wr [$];
    batch_t               mb;
    wr_t                  mw;

    int  vectors = 0, miscompares = 0;
    int  run_cnt = 0, rd_acc_cnt = 0;
    bit  stall_en = 0;
    int  max_lat = 1;
    bit  pend = 0;
    int  pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    knn_memory_control_mc #(
        .W(W), .M(M), .N(N), .TYPE_W(TYPE_W), .L(L), .P(P), .NUM_INPUTS(NI),
        .ADDR_W(ADDR_W), .BASE_T_ADDR(BT), .BASE_I_ADDR(BI)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .waitrequest(waitrequest),
        .readdatavalid(readdatavalid), .readdata(readdata), .read(read), .write(write),
        .address(address), .writedata(writedata), .input_data(input_data),
        .training_data(training_data), .training_data_type(training_data_type),
        .channel_valid(channel_valid), .read_done(read_done), .done(done),
        .inference_done(inference_done), .inferred_type(inferred_type),
        .run_done(run_done), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rd_mem(input logic [31:0] a);
        return mem[a[8:1]];
    endfunction

    task automatic fill_mem(input bit fixed);
        for (int j = 0; j < 256; j++) mem[j] = W'($urandom);
        if (fixed) begin
            mem[(BT + 0 * R) / S] = 16'h0001;
            mem[(BT + 1 * R) / S] = 16'h0002;
        end
    endtask

    // Expected traffic derived straight from the record layout and batching rules.
    task automatic build_model();
        batch_t      bt;
        logic [31:0] a;
        logic [W-1:0] wd;
        int          t;
        exp_rd.delete(); exp_b.delete(); exp_wr.delete();
        for (int i = 0; i < NI; i++) begin
            bt.in_v = '0;
            for (int k = 0; k < F; k++) begin
                a = BI + i * R + (k + 1) * S;
                exp_rd.push_back(a);
                bt.in_v[k*W +: W] = rd_mem(a);
            end
            for (int b = 0; b < NB; b++) begin
                bt.tr = '0; bt.ty = '0; bt.v = '0;
                for (int c = 0; c < P; c++) begin
                    t = b * P + c;
                    if (t < L) begin
                        for (int k = 0; k <= F; k++) begin
                            a = BT + t * R + k * S;
                            exp_rd.push_back(a);
                            wd = rd_mem(a);
                            if (k == 0) bt.ty[c*TYPE_W +: TYPE_W] = wd[TYPE_W-1:0];
                            else        bt.tr[(c*F + k - 1)*W +: W] = wd;
                        end
                        bt.v[c] = 1'b1;
                    end
                end
                exp_b.push_back(bt);
            end
            exp_wr.push_back('{BI + i * R, W'(inf_t[i])});
        end
    endtask

    // Memory slave plus traffic monitor; runs at negedge so accept decisions match the next posedge.
    always @(negedge clk) begin
        if (read && write) check_eq("rw_exclusive", 128'(1), 128'(0));
        if (read_done) begin
            if (exp_b.size() == 0) begin
                check_eq("batch_unexpected", 128'(channel_valid), 128'hdead);
            end else begin
                mb = exp_b.pop_front();
                check_eq("input_data", 128'(input_data), 128'(mb.in_v));
                check_eq("training_data", 128'(training_data), 128'(mb.tr));
                check_eq("training_type", 128'(training_data_type), 128'(mb.ty));
                check_eq("channel_valid", 128'(channel_valid), 128'(mb.v));
            end
        end
        if (run_done) run_cnt++;

        readdatavalid = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                readdatavalid = 1'b1;
                readdata      = rd_mem(pend_addr);
                pend          = 1'b0;
            end
        end
        waitrequest = stall_en ? ($urandom_range(1, 0) != 0) : 1'b0;
        if (read && !waitrequest) begin
            check_eq("one_outstanding", 128'(pend), 128'(0));
            if (exp_rd.size() == 0) check_eq("rd_unexpected", 128'(address), 128'hffffffff);
            else                    check_eq("rd_addr", 128'(address), 128'(exp_rd.pop_front()));
            pend      = 1'b1;
            pend_cnt  = $urandom_range(max_lat, 1);
            pend_addr = address;
            rd_acc_cnt++;
        end
        if (write && !waitrequest) begin
            if (exp_wr.size() == 0) begin
                check_eq("wr_unexpected", 128'(address), 128'hffffffff);
            end else begin
                mw = exp_wr.pop_front();
                check_eq("wr_addr", 128'(address), 128'(mw.a));
                check_eq("wr_data", 128'(writedata), 128'(mw.d));
            end
        end
    end

    task automatic wait_for(input int which, input string tag, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if ((which == 0 && read_done) || (which == 1 && run_done) ||
                (which == 2 && read && rd_acc_cnt >= F + 2)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq(tag, 128'(0), 128'(1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic prep(input bit stall, input int lat, input bit fixed, input bit early);
        stall_en = stall;
        max_lat  = lat;
        fill_mem(fixed);
        for (int i = 0; i < NI; i++) inf_t[i] = TYPE_W'($urandom_range(15, 1));
        if (fixed) inf_t[0] = 4'd3;
        if (early) inf_t[0] = 4'd5;
        build_model();
        run_cnt    = 0;
        rd_acc_cnt = 0;
    endtask

    task automatic run_scenario(input bit stall, input int lat, input bit early,
                                input bit noise, input bit fixed);
        bit ok;
        prep(stall, lat, fixed, early);
        pulse_start();
        check_eq("busy_after_start", 128'(idle), 128'(0));
        for (int i = 0; i < NI; i++) begin
            for (int b = 0; b < NB; b++) begin
                wait_for(0, "timeout_read_done", ok);
                if (!ok) return;
                if (early && b == 0) begin
                    inference_done = 1'b1;
                    inferred_type  = ~inf_t[i];
                    @(negedge clk);
                    inferred_type  = inf_t[i];
                    @(negedge clk);
                    inference_done = 1'b0;
                end
                if (noise && b == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                repeat ($urandom_range(3, 0)) @(negedge clk);
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
                if (noise && b < NB - 1) begin
                    @(negedge clk);
                    done = 1'b1;
                    @(negedge clk);
                    done = 1'b0;
                end
            end
            if (early) begin
                @(negedge clk);
                check_eq("early_write", 128'(write), 128'(1));
            end else begin
                repeat ($urandom_range(3, 0)) @(negedge clk);
                inference_done = 1'b1;
                inferred_type  = inf_t[i];
                @(negedge clk);
                inference_done = 1'b0;
            end
        end
        wait_for(1, "timeout_run_done", ok);
        repeat (6) @(negedge clk);
        check_eq("reads_left", 128'(exp_rd.size()), 128'(0));
        check_eq("batches_left", 128'(exp_b.size()), 128'(0));
        check_eq("writes_left", 128'(exp_wr.size()), 128'(0));
        check_eq("run_done_count", 128'(run_cnt), 128'(1));
        check_eq("idle_at_end", 128'(idle), 128'(1));
    endtask

    task automatic reset_scenario();
        bit ok;
        prep(1'b1, 4, 1'b0, 1'b0);
        pulse_start();
        wait_for(2, "timeout_fetch_tr", ok);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_read", 128'(read), 128'(0));
        check_eq("rst_idle", 128'(idle), 128'(1));
        check_eq("rst_input_data", 128'(input_data), 128'(0));
        check_eq("rst_address", 128'(address), 128'(BT));
        exp_rd.delete(); exp_b.delete(); exp_wr.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_scenario(1'b1, 4, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        done           = 1'b0;
        inference_done = 1'b0;
        inferred_type  = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_read", 128'(read), 128'(0));
        check_eq("reset_write", 128'(write), 128'(0));
        check_eq("reset_read_done", 128'(read_done), 128'(0));
        check_eq("reset_run_done", 128'(run_done), 128'(0));
        check_eq("reset_channel_valid", 128'(channel_valid), 128'(0));
        check_eq("reset_address", 128'(address), 128'(BT));
        check_eq("reset_input_data", 128'(input_data), 128'(0));
        check_eq("reset_training_data", 128'(training_data), 128'(0));
        check_eq("reset_training_type", 128'(training_data_type), 128'(0));
        check_eq("reset_idle", 128'(idle), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_scenario(1'b0, 1, 1'b0, 1'b0, 1'b1);
        run_scenario(1'b1, 4, 1'b0, 1'b0, 1'b0);
        run_scenario(1'b1, 4, 1'b1, 1'b0, 1'b0);
        run_scenario(1'b1, 4, 1'b0, 1'b1, 1'b0);
        reset_scenario();
        repeat (3) run_scenario(1'b1, 4, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
